// File: rtl/mgmt_disk_responder_if.sv
// Avalon-MM mgmt bus between the top-level bridge (master) and the disk responder (slave).
interface mgmt_disk_responder_if;
   logic [7:0]  mgmt_address;
   logic        mgmt_read;
   logic        mgmt_write;
   logic [31:0] mgmt_writedata;
   logic [3:0]  mgmt_byteenable;
   logic        mgmt_waitrequest;
   logic [31:0] mgmt_readdata;
   logic        mgmt_readdatavalid;

   modport master (
      output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata, mgmt_byteenable,
      input  mgmt_waitrequest, mgmt_readdata, mgmt_readdatavalid
   );

   modport slave (
      input  mgmt_address, mgmt_read, mgmt_write, mgmt_writedata, mgmt_byteenable,
      output mgmt_waitrequest, mgmt_readdata, mgmt_readdatavalid
   );
endinterface

// File: rtl/mgmt_disk_responder.sv
// Mgmt-bus responder: shared sector buffer plus a disk-op handshake between core and host.
// Optional PEND timeout is enabled by defining MGMT_RESP_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | no disk op outstanding
// S_PEND | op latched, disk_op_read/write raised, waiting for host RESULT
// S_OK   | one-cycle success pulse, back to idle next cycle
// S_ERR  | one-cycle failure pulse (host error or timeout), back to idle next cycle
module mgmt_disk_responder #(
   parameter int          BUF_WORDS   = 128,
   parameter logic [31:0] DEV_ID      = 32'h4D44_0001,
   parameter int          TIMEOUT_CYC = 90500000
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   mgmt_disk_responder_if.slave  mgmt,
   input  logic                  core_rd,
   input  logic                  core_wr,
   input  logic [31:0]           core_lba,
   input  logic [7:0]            core_count,
   input  logic                  core_dev,
   input  logic [6:0]            buf_addr,
   input  logic                  buf_we,
   input  logic [31:0]           buf_wdata,
   output logic [31:0]           buf_rdata,
   output logic                  disk_op_read,
   output logic                  disk_op_write,
   output logic                  disk_op_device,
   output logic                  disk_result_ok,
   output logic                  disk_result_error,
   output logic                  busy
);

   localparam int AW = $clog2(BUF_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_OK, S_ERR} state_t;

   state_t         state;
   logic [31:0]    mem [BUF_WORDS];
   logic           wait_init;
   logic           buf_hit;
   logic           collide;
   logic           waitreq;
   logic           wr_acc;
   logic           rd_acc;
   logic           mbuf_we;
   logic           result_wr;
   logic           tmo_hit;
   logic [AW-1:0]  midx;
   logic [AW-1:0]  cidx;
   logic [31:0]    op_lba;
   logic [7:0]     op_count;
   logic           op_dir;
   logic [31:0]    rd_mux;

   assign midx    = mgmt.mgmt_address[AW-1:0];
   assign cidx    = buf_addr[AW-1:0];
   assign buf_hit = (mgmt.mgmt_address < 8'(BUF_WORDS));

   // Core buffer writes always win; the mgmt side is stalled and retries.
   assign collide = buf_we & buf_hit & (mgmt.mgmt_read | mgmt.mgmt_write);
   assign waitreq = wait_init | collide;
   assign mgmt.mgmt_waitrequest = waitreq;

   assign wr_acc    = mgmt.mgmt_write & ~waitreq;
   assign rd_acc    = mgmt.mgmt_read & ~mgmt.mgmt_write & ~waitreq;
   assign mbuf_we   = wr_acc & buf_hit;
   assign result_wr = wr_acc & (mgmt.mgmt_address == 8'h83) & mgmt.mgmt_byteenable[0];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) wait_init <= 1'b1;
      else          wait_init <= 1'b0;
   end

   // Buffer has no reset; only one writer per cycle is possible thanks to the stall.
   always_ff @(posedge clk_sys) begin
      if (buf_we) begin
         mem[cidx] <= buf_wdata;
      end else if (mbuf_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mgmt.mgmt_byteenable[b]) mem[midx][8*b +: 8] <= mgmt.mgmt_writedata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) buf_rdata <= '0;
      else          buf_rdata <= mem[cidx];
   end

   always_comb begin
      rd_mux = '0;
      if (buf_hit) begin
         rd_mux = mem[midx];
      end else begin
         case (mgmt.mgmt_address)
            8'h80:   rd_mux = {29'b0, disk_op_device, op_dir, state == S_PEND};
            8'h81:   rd_mux = op_lba;
            8'h82:   rd_mux = {24'b0, op_count};
            8'h84:   rd_mux = DEV_ID;
            default: rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mgmt.mgmt_readdata      <= '0;
         mgmt.mgmt_readdatavalid <= 1'b0;
      end else begin
         mgmt.mgmt_readdatavalid <= rd_acc;
         if (rd_acc) mgmt.mgmt_readdata <= rd_mux;
      end
   end

`ifdef MGMT_RESP_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)              tmo_cnt <= '0;
      else if (state == S_PEND)  tmo_cnt <= tmo_cnt + 32'd1;
      else                       tmo_cnt <= '0;
   end

   assign tmo_hit = (state == S_PEND) && (tmo_cnt == 32'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state             <= S_IDLE;
         op_lba            <= '0;
         op_count          <= '0;
         op_dir            <= 1'b0;
         disk_op_device    <= 1'b0;
         disk_op_read      <= 1'b0;
         disk_op_write     <= 1'b0;
         disk_result_ok    <= 1'b0;
         disk_result_error <= 1'b0;
         busy              <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (core_wr | core_rd) begin
                  state          <= S_PEND;
                  busy           <= 1'b1;
                  op_lba         <= core_lba;
                  op_count       <= core_count;
                  disk_op_device <= core_dev;
                  op_dir         <= core_wr;
                  disk_op_write  <= core_wr;
                  disk_op_read   <= ~core_wr;
               end
            end
            S_PEND: begin
               // Host RESULT outranks a timeout landing in the same cycle.
               if (result_wr && mgmt.mgmt_writedata[1]) begin
                  state             <= S_ERR;
                  disk_result_error <= 1'b1;
                  disk_op_read      <= 1'b0;
                  disk_op_write     <= 1'b0;
               end else if (result_wr && mgmt.mgmt_writedata[0]) begin
                  state          <= S_OK;
                  disk_result_ok <= 1'b1;
                  disk_op_read   <= 1'b0;
                  disk_op_write  <= 1'b0;
               end else if (tmo_hit) begin
                  state             <= S_ERR;
                  disk_result_error <= 1'b1;
                  disk_op_read      <= 1'b0;
                  disk_op_write     <= 1'b0;
               end
            end
            S_OK, S_ERR: begin
               state             <= S_IDLE;
               disk_result_ok    <= 1'b0;
               disk_result_error <= 1'b0;
               busy              <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mgmt_disk_responder.sv
// Self-checking bench for mgmt_disk_responder: directed scenarios plus randomized traffic vs a reference model.
module tb_mgmt_disk_responder;

   localparam int          TMO = 16;
   localparam logic [31:0] ID  = 32'h4D44_0001;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        core_rd, core_wr, core_dev, buf_we;
   logic [31:0] core_lba, buf_wdata, buf_rdata;
   logic [7:0]  core_count;
   logic [6:0]  buf_addr;
   logic        disk_op_read, disk_op_write, disk_op_device;
   logic        disk_result_ok, disk_result_error, busy;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_mem [128];
   bit          m_pend, m_dir, m_dev;
   logic [31:0] m_lba;
   logic [7:0]  m_count;

   always #5 clk_sys = ~clk_sys;

   mgmt_disk_responder_if bus ();

   mgmt_disk_responder #(.BUF_WORDS(128), .DEV_ID(ID), .TIMEOUT_CYC(TMO)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .mgmt(bus),
      .core_rd(core_rd), .core_wr(core_wr), .core_lba(core_lba), .core_count(core_count),
      .core_dev(core_dev), .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata),
      .buf_rdata(buf_rdata), .disk_op_read(disk_op_read), .disk_op_write(disk_op_write),
      .disk_op_device(disk_op_device), .disk_result_ok(disk_result_ok),
      .disk_result_error(disk_result_error), .busy(busy)
   );

   function automatic logic [31:0] model_read(input logic [7:0] a);
      if (a < 8'h80) return m_mem[a[6:0]];
      case (a)
         8'h80:   return {29'b0, m_dev, m_dir, m_pend};
         8'h81:   return m_lba;
         8'h82:   return {24'b0, m_count};
         8'h84:   return ID;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
      return r;
   endfunction

   // bus drivers: called at posedge+1, return at posedge+1
   task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output int waits, output bit vld_ok);
      bit acc;
      acc = 0; waits = 0; vld_ok = 1;
      bus.mgmt_address = a; bus.mgmt_read = 1'b1;
      while (!acc && waits <= 50) begin
         @(negedge clk_sys); acc = !bus.mgmt_waitrequest;
         @(posedge clk_sys); #1;
         if (!acc) begin
            waits++;
            if (bus.mgmt_readdatavalid) vld_ok = 0;
         end
      end
      bus.mgmt_read = 1'b0;
      if (bus.mgmt_readdatavalid !== 1'b1) vld_ok = 0;
      d = bus.mgmt_readdata;
      @(posedge clk_sys); #1;
      if (bus.mgmt_readdatavalid !== 1'b0) vld_ok = 0;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                            input bit with_rd, output int waits, output logic rdv_seen);
      bit acc;
      acc = 0; waits = 0;
      bus.mgmt_address = a; bus.mgmt_writedata = d; bus.mgmt_byteenable = be;
      bus.mgmt_write = 1'b1; bus.mgmt_read = with_rd;
      while (!acc && waits <= 50) begin
         @(negedge clk_sys); acc = !bus.mgmt_waitrequest;
         @(posedge clk_sys); #1;
         if (!acc) waits++;
      end
      bus.mgmt_write = 1'b0; bus.mgmt_read = 1'b0;
      rdv_seen = bus.mgmt_readdatavalid;
   endtask

   task automatic core_write(input logic [6:0] a, input logic [31:0] d);
      buf_addr = a; buf_wdata = d; buf_we = 1'b1;
      @(posedge clk_sys); #1;
      buf_we = 1'b0;
   endtask

   task automatic core_read(input logic [6:0] a, output logic [31:0] d);
      buf_addr = a;
      @(posedge clk_sys); #1;
      d = buf_rdata;
   endtask

   task automatic core_req(input bit rd, input bit wr, input logic [31:0] lba, input logic [7:0] cnt, input bit dev);
      core_rd = rd; core_wr = wr; core_lba = lba; core_count = cnt; core_dev = dev;
      @(posedge clk_sys); #1;
      core_rd = 1'b0; core_wr = 1'b0;
      if (!m_pend) begin
         m_pend = 1; m_dir = wr; m_dev = dev; m_lba = lba; m_count = cnt;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; int w; bit v;
      repeat (3) @(posedge clk_sys);
      #1;
      checks++;
      if ({bus.mgmt_waitrequest, bus.mgmt_readdatavalid, disk_op_read, disk_op_write, disk_op_device,
           disk_result_ok, disk_result_error, busy} !== 8'b1000_0000) begin
         errors++; $display("FAIL reset_outputs got %b exp 10000000", {bus.mgmt_waitrequest,
            bus.mgmt_readdatavalid, disk_op_read, disk_op_write, disk_op_device, disk_result_ok,
            disk_result_error, busy});
      end
      checks++;
      if (bus.mgmt_readdata !== 32'h0 || buf_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_data got %h/%h exp 0/0", bus.mgmt_readdata, buf_rdata);
      end
      reset_n = 1'b1;
      bus_read(8'h84, d, w, v);
      checks++;
      if (w != 1) begin errors++; $display("FAIL reset_first_wait got %0d exp 1", w); end
      checks++;
      if (!v || d !== ID) begin errors++; $display("FAIL id_read got %h vld %0d exp %h", d, v, ID); end
   endtask

   task automatic init_buffer();
      logic [31:0] d;
      for (int i = 0; i < 128; i++) begin
         d = $urandom;
         core_write(7'(i), d);
         m_mem[i] = d;
      end
   endtask

   task automatic test_disk_write_ok();
      logic [31:0] d; int w; bit v; logic r;
      core_req(1'b0, 1'b1, 32'h1234, 8'd1, 1'b1);
      checks++;
      if ({disk_op_read, disk_op_write, disk_op_device, busy} !== 4'b0111) begin
         errors++; $display("FAIL op_write_raise got %b exp 0111", {disk_op_read, disk_op_write, disk_op_device, busy});
      end
      core_req(1'b1, 1'b0, 32'h9999, 8'd5, 1'b0);
      bus_read(8'h80, d, w, v);
      checks++;
      if (!v || d !== 32'h7 || d !== model_read(8'h80)) begin errors++; $display("FAIL status got %h exp 7", d); end
      bus_read(8'h81, d, w, v);
      checks++;
      if (!v || d !== 32'h1234) begin errors++; $display("FAIL lba got %h exp 1234", d); end
      bus_read(8'h82, d, w, v);
      checks++;
      if (!v || d !== model_read(8'h82)) begin errors++; $display("FAIL count got %h exp %h", d, model_read(8'h82)); end
      bus_write(8'h83, 32'h1, 4'hF, 1'b0, w, r);
      m_pend = 0;
      checks++;
      if ({disk_result_ok, disk_result_error, disk_op_read, disk_op_write, busy} !== 5'b10001) begin
         errors++; $display("FAIL ok_pulse got %b exp 10001", {disk_result_ok, disk_result_error, disk_op_read, disk_op_write, busy});
      end
      @(posedge clk_sys); #1;
      checks++;
      if ({disk_result_ok, disk_result_error, busy} !== 3'b000) begin
         errors++; $display("FAIL ok_end got %b exp 000", {disk_result_ok, disk_result_error, busy});
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] d; int w; bit v; logic r;
      core_write(7'd5, 32'h0); m_mem[5] = 32'h0;
      bus_write(8'h05, 32'hAABBCCDD, 4'b0101, 1'b0, w, r);
      m_mem[5] = merge(m_mem[5], 32'hAABBCCDD, 4'b0101);
      bus_read(8'h05, d, w, v);
      checks++;
      if (!v || d !== 32'h00BB00DD || d !== m_mem[5]) begin errors++; $display("FAIL be_mgmt got %h exp 00bb00dd", d); end
      core_read(7'd5, d);
      checks++;
      if (d !== 32'h00BB00DD) begin errors++; $display("FAIL be_core got %h exp 00bb00dd", d); end
   endtask

   task automatic test_collision();
      logic [31:0] d, md, cd, old; logic [6:0] ma, ca; int w; bit v; logic r;
      ma = 7'($urandom_range(0, 127));
      ca = ma + 7'($urandom_range(1, 126));
      md = $urandom; cd = $urandom;
      bus.mgmt_address = {1'b0, ma}; bus.mgmt_writedata = md; bus.mgmt_byteenable = 4'hF; bus.mgmt_write = 1'b1;
      buf_addr = ca; buf_wdata = cd; buf_we = 1'b1;
      @(negedge clk_sys);
      checks++;
      if (bus.mgmt_waitrequest !== 1'b1) begin errors++; $display("FAIL coll_wait_hi got %b exp 1", bus.mgmt_waitrequest); end
      @(posedge clk_sys); #1;
      buf_we = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (bus.mgmt_waitrequest !== 1'b0) begin errors++; $display("FAIL coll_wait_lo got %b exp 0", bus.mgmt_waitrequest); end
      @(posedge clk_sys); #1;
      bus.mgmt_write = 1'b0;
      m_mem[ma] = md; m_mem[ca] = cd;
      core_read(ca, d);
      checks++;
      if (d !== m_mem[ca]) begin errors++; $display("FAIL coll_core got %h exp %h", d, m_mem[ca]); end
      bus_read({1'b0, ma}, d, w, v);
      checks++;
      if (!v || d !== m_mem[ma]) begin errors++; $display("FAIL coll_mgmt got %h exp %h", d, m_mem[ma]); end
      // core read of a word the host writes in the same cycle sees the old value
      old = m_mem[ca]; md = ~old;
      buf_addr = ca;
      bus_write({1'b0, ca}, md, 4'hF, 1'b0, w, r);
      m_mem[ca] = md;
      checks++;
      if (buf_rdata !== old) begin errors++; $display("FAIL rd_old got %h exp %h", buf_rdata, old); end
      @(posedge clk_sys); #1;
      checks++;
      if (buf_rdata !== md) begin errors++; $display("FAIL rd_new got %h exp %h", buf_rdata, md); end
   endtask

   task automatic test_rw_same();
      logic [31:0] d, nd; logic [7:0] a; int w; bit v; logic r;
      a = 8'($urandom_range(0, 127)); nd = $urandom;
      bus_write(a, nd, 4'hF, 1'b1, w, r);
      m_mem[a[6:0]] = nd;
      checks++;
      if (r !== 1'b0) begin errors++; $display("FAIL rw_no_rdv got %b exp 0", r); end
      bus_read(a, d, w, v);
      checks++;
      if (!v || d !== nd) begin errors++; $display("FAIL rw_write_won got %h exp %h", d, nd); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] al [5];
      al[0] = 8'h84; al[1] = 8'h80; al[2] = 8'h10; al[3] = 8'h81; al[4] = 8'h11;
      bus.mgmt_read = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.mgmt_address = al[i];
         @(posedge clk_sys); #1;
         checks++;
         if (bus.mgmt_readdatavalid !== 1'b1 || bus.mgmt_readdata !== model_read(al[i])) begin
            errors++; $display("FAIL b2b_%0d got %h vld %b exp %h", i, bus.mgmt_readdata,
                               bus.mgmt_readdatavalid, model_read(al[i]));
         end
      end
      bus.mgmt_read = 1'b0;
      @(posedge clk_sys); #1;
      checks++;
      if (bus.mgmt_readdatavalid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", bus.mgmt_readdatavalid); end
   endtask

   task automatic test_result_error_idle();
      int w; logic r; int pulses;
      core_req(1'b1, 1'b0, $urandom, 8'($urandom), 1'($urandom));
      checks++;
      if ({disk_op_read, disk_op_write} !== 2'b10) begin errors++; $display("FAIL op_read_raise got %b exp 10", {disk_op_read, disk_op_write}); end
      bus_write(8'h83, 32'h1, 4'b1110, 1'b0, w, r);
      bus_write(8'h83, 32'h0, 4'hF, 1'b0, w, r);
      checks++;
      if ({disk_result_ok, disk_result_error, disk_op_read} !== 3'b001) begin
         errors++; $display("FAIL result_noeffect got %b exp 001", {disk_result_ok, disk_result_error, disk_op_read});
      end
      bus_write(8'h83, 32'h3, 4'hF, 1'b0, w, r);
      m_pend = 0;
      checks++;
      if ({disk_result_ok, disk_result_error, disk_op_read} !== 3'b010) begin
         errors++; $display("FAIL err_pulse got %b exp 010", {disk_result_ok, disk_result_error, disk_op_read});
      end
      @(posedge clk_sys); #1;
      pulses = 0;
      bus_write(8'h83, 32'h1, 4'hF, 1'b0, w, r);
      for (int i = 0; i < 4; i++) begin
         pulses += int'(disk_result_ok) + int'(disk_result_error) + int'(busy);
         @(posedge clk_sys); #1;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL idle_result got %0d exp 0", pulses); end
   endtask

   task automatic test_random();
      logic [31:0] d, exp; logic [7:0] a; logic [3:0] be; int w, op, kind; bit v; logic r;
      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 4);
         case (op)
            0: begin
               a = 8'($urandom_range(0, 127)); d = $urandom; be = 4'($urandom);
               bus_write(a, d, be, 1'b0, w, r);
               m_mem[a[6:0]] = merge(m_mem[a[6:0]], d, be);
               checks++;
               if (w != 0) begin errors++; $display("FAIL rnd_wr_wait got %0d exp 0", w); end
            end
            1: begin
               a = 8'($urandom_range(0, 127)); d = $urandom;
               core_write(a[6:0], d);
               m_mem[a[6:0]] = d;
            end
            2: begin
               a = 8'($urandom);
               bus_read(a, d, w, v);
               exp = model_read(a);
               checks++;
               if (!v || d !== exp) begin errors++; $display("FAIL rnd_rd[%h] got %h vld %0d exp %h", a, d, v, exp); end
            end
            3: begin
               a = 8'($urandom_range(0, 127));
               core_read(a[6:0], d);
               checks++;
               if (d !== m_mem[a[6:0]]) begin errors++; $display("FAIL rnd_core[%h] got %h exp %h", a, d, m_mem[a[6:0]]); end
            end
            default: begin
               if (!m_pend) begin
                  kind = $urandom_range(1, 3);
                  core_req(kind[0], kind[1], $urandom, 8'($urandom), 1'($urandom));
                  checks++;
                  if ({disk_op_read, disk_op_write, disk_op_device, busy} !== {!m_dir, m_dir, m_dev, 1'b1}) begin
                     errors++; $display("FAIL rnd_req got %b exp %b", {disk_op_read, disk_op_write, disk_op_device, busy},
                                        {!m_dir, m_dir, m_dev, 1'b1});
                  end
               end else begin
                  d = 32'($urandom_range(0, 3));
                  bus_write(8'h83, d, 4'hF, 1'b0, w, r);
                  checks++;
                  if ({disk_result_ok, disk_result_error, disk_op_read | disk_op_write} !==
                      {d == 32'h1, d[1], d == 32'h0}) begin
                     errors++; $display("FAIL rnd_result %0d got %b exp %b", d,
                        {disk_result_ok, disk_result_error, disk_op_read | disk_op_write}, {d == 32'h1, d[1], d == 32'h0});
                  end
                  if (d != 0) begin
                     m_pend = 0;
                     @(posedge clk_sys); #1;
                  end
               end
            end
         endcase
      end
      if (m_pend) begin
         bus_write(8'h83, 32'h1, 4'hF, 1'b0, w, r);
         m_pend = 0;
         @(posedge clk_sys); #1;
      end
   endtask

   task automatic test_timeout();
      int first_err, w; logic r;
      core_req(1'b1, 1'b0, 32'h55, 8'd2, 1'b0);
      first_err = -1;
`ifdef MGMT_RESP_TIMEOUT_EN
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk_sys); #1;
         if (disk_result_error && first_err < 0) first_err = k;
      end
      m_pend = 0;
      checks++;
      if (first_err != TMO) begin errors++; $display("FAIL timeout_cycle got %0d exp %0d", first_err, TMO); end
      checks++;
      if ({disk_op_read, busy} !== 2'b00) begin errors++; $display("FAIL timeout_idle got %b exp 00", {disk_op_read, busy}); end
`else
      for (int k = 1; k <= 1000; k++) begin
         @(posedge clk_sys); #1;
         if ((disk_result_error || disk_result_ok) && first_err < 0) first_err = k;
      end
      checks++;
      if (first_err != -1 || disk_op_read !== 1'b1) begin
         errors++; $display("FAIL no_timeout got pulse@%0d op %b exp none/1", first_err, disk_op_read);
      end
      bus_write(8'h83, 32'h1, 4'hF, 1'b0, w, r);
      m_pend = 0;
      checks++;
      if (disk_result_ok !== 1'b1) begin errors++; $display("FAIL hold_then_ok got %b exp 1", disk_result_ok); end
      @(posedge clk_sys); #1;
`endif
   endtask

   task automatic test_reset_midop();
      logic [31:0] d; int w; bit v;
      core_req(1'b0, 1'b1, 32'hCAFE, 8'd9, 1'b1);
      bus.mgmt_address = 8'h84; bus.mgmt_read = 1'b1;
      @(posedge clk_sys); #1;
      bus.mgmt_read = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.mgmt_readdatavalid, disk_op_read, disk_op_write, disk_result_ok, disk_result_error, busy,
           bus.mgmt_waitrequest} !== 7'b0000001) begin
         errors++; $display("FAIL midop_reset got %b exp 0000001", {bus.mgmt_readdatavalid, disk_op_read,
            disk_op_write, disk_result_ok, disk_result_error, busy, bus.mgmt_waitrequest});
      end
      m_pend = 0; m_dir = 0; m_dev = 0; m_lba = 0; m_count = 0;
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      bus_read(8'h80, d, w, v);
      checks++;
      if (w != 1 || !v || d !== model_read(8'h80)) begin errors++; $display("FAIL midop_status got %h waits %0d exp 0/1", d, w); end
      bus_read(8'h81, d, w, v);
      checks++;
      if (!v || d !== 32'h0) begin errors++; $display("FAIL midop_lba got %h exp 0", d); end
   endtask

   initial begin
      core_rd = 0; core_wr = 0; core_dev = 0; core_lba = 0; core_count = 0;
      buf_we = 0; buf_addr = 0; buf_wdata = 0;
      bus.mgmt_address = 0; bus.mgmt_read = 0; bus.mgmt_write = 0;
      bus.mgmt_writedata = 0; bus.mgmt_byteenable = 0;
      m_pend = 0; m_dir = 0; m_dev = 0; m_lba = 0; m_count = 0;
      test_reset();
      init_buffer();
      test_disk_write_ok();
      test_byte_enable();
      test_collision();
      test_rw_same();
      test_back_to_back();
      test_result_error_idle();
      test_random();
      test_timeout();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
